// File: rtl/vga_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : vga_axil_slave
// Purpose  : AXI4-Lite slave front-end for the VGA text controller. Terminates
//            the five AXI-Lite channels and converts them into the strobe
//            interface of the VGA top: registered write address/data/strobe
//            with a one-cycle write pulse, and a registered read address with
//            a one-cycle read request. Read data is captured a fixed number
//            of cycles after the request and returned on the R channel.
// Ports    : clk_i, rst_i               - clock, synchronous active-high reset
//            s_axil_aw*/w*/b*           - AXI-Lite write channels
//            s_axil_ar*/r*              - AXI-Lite read channels
//            axil_waddr_o/wdata_o/wstrb_o, axil_wready_o - write strobe side
//            axil_raddr_o, axil_rreq_o, axil_rdata_i     - read strobe side
// Options  : VGA_AXIL_SLVERR_EN - decode addresses and answer SLVERR for
//            accesses outside the text buffer / colour registers / font map.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axil_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 15,
  parameter int READ_LATENCY     = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  output logic [1:0]                      s_axil_bresp,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
  output logic                            axil_wready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_o,
  output logic                            axil_rreq_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } rd_state_t;

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  logic                          aw_full_q;
  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr_q;
  logic                          w_full_q;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                          issued_q;
  logic [1:0]                    bresp_pend_q;
  logic                          bvalid_q;
  logic [1:0]                    bresp_q;
  logic [C_AXI_ADDR_WIDTH-1:0]   waddr_out_q;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_out_q;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb_out_q;
  logic                          wpulse_q;

  logic wr_ok;
  logic rd_ok;
  logic w_issue;

`ifdef VGA_AXIL_SLVERR_EN
  // bit14: text buffer (600 words); bit13: colour registers; else font memory
  assign wr_ok = awaddr_q[14] ? (awaddr_q[13:0] < 14'h0960) :
                 awaddr_q[13] ? (awaddr_q[12:0] <= 13'h0014) : 1'b1;
  assign rd_ok = s_axil_araddr[14] ? (s_axil_araddr[13:0] < 14'h0960) :
                 s_axil_araddr[13] ? (s_axil_araddr[12:0] <= 13'h0014) : 1'b1;
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // The VGA top re-samples the write outputs one cycle after the pulse, so a
  // new issue is suppressed in the cycle directly after an issue. That same
  // gap lets bvalid be raised one cycle after the pulse without the issue
  // condition missing a response that is still in flight.
  assign w_issue = aw_full_q & w_full_q & (~bvalid_q | s_axil_bready) & ~issued_q;

  assign s_axil_awready = ~aw_full_q;
  assign s_axil_wready  = ~w_full_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign axil_waddr_o   = waddr_out_q;
  assign axil_wdata_o   = wdata_out_q;
  assign axil_wstrb_o   = wstrb_out_q;
  assign axil_wready_o  = wpulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full_q    <= 1'b0;
      awaddr_q     <= '0;
      w_full_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      issued_q     <= 1'b0;
      bresp_pend_q <= RESP_OKAY;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      waddr_out_q  <= '0;
      wdata_out_q  <= '0;
      wstrb_out_q  <= '0;
      wpulse_q     <= 1'b0;
    end else begin
      // Holding flags cannot be set and cleared in the same cycle: an issue
      // needs the flag set, which also deasserts the channel's ready.
      if (s_axil_awvalid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_axil_awaddr;
      end else if (w_issue) begin
        aw_full_q <= 1'b0;
      end

      if (s_axil_wvalid && !w_full_q) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axil_wdata;
        wstrb_q  <= s_axil_wstrb;
      end else if (w_issue) begin
        w_full_q <= 1'b0;
      end

      issued_q <= w_issue;
      wpulse_q <= w_issue & wr_ok;

      if (w_issue) begin
        bresp_pend_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          waddr_out_q <= awaddr_q;
          wdata_out_q <= wdata_q;
          wstrb_out_q <= wstrb_q;
        end
      end

      if (issued_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_pend_q;
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  rd_state_t                   state_q;
  rd_state_t                   state_d;
  logic [2:0]                  cnt_q;
  logic [2:0]                  cnt_d;
  logic [C_AXI_ADDR_WIDTH-1:0] raddr_q;
  logic                        rreq_q;
  logic                        rerr_q;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                  rresp_q;
  logic                        ar_hs;

  assign s_axil_arready = (state_q == S_IDLE);
  assign s_axil_rvalid  = (state_q == S_RESP);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign axil_raddr_o   = raddr_q;
  assign axil_rreq_o    = rreq_q;
  assign ar_hs          = s_axil_arvalid & (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (s_axil_arvalid) begin
          state_d = S_WAIT;
          cnt_d   = 3'(READ_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (s_axil_rready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      raddr_q <= '0;
      rreq_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rreq_q  <= ar_hs & rd_ok;
      if (ar_hs) begin
        raddr_q <= s_axil_araddr;
        rerr_q  <= ~rd_ok;
      end
      // A rejected read still walks through WAIT so the response timing
      // does not depend on whether the address decoded.
      if (state_q == S_WAIT && cnt_q == 3'd0) begin
        rdata_q <= rerr_q ? '0 : axil_rdata_i;
        rresp_q <= rerr_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule
`default_nettype wire
